// File: rtl/edge_mcu_tiled.sv
// edge_mcu_tiled: tiled edge-pipeline control FSM; read/gray/buf1/gradient/buf2/write handshakes per OUT_W x OUT_W tile.
// Define EDGE_MCU_PERF_CNT_EN to add the o_stall_cycles wait-state counter.
module edge_mcu_tiled #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int OUT_W = 3,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RBASE = '0,
  parameter logic [ADDR_W-1:0] WBASE = 32'h0010_0000,
  localparam int TX = (IMG_W - 2) / OUT_W,
  localparam int TY = (IMG_H - 2) / OUT_W,
  localparam int XW = $clog2(TX + 1),
  localparam int YW = $clog2(TY + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_read_complete,
  input  logic              i_grayscale_data_ready,
  input  logic              i_gradient_data_ready,
  input  logic              i_start_next_write,
  input  logic              i_write_complete,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_re,
  output logic              o_grayscale_start,
  output logic              o_b1_save,
  output logic              o_b1_clear,
  output logic              o_gradient_start,
  output logic              o_b2_save,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_complete,
  output logic              o_aborted,
  output logic [XW-1:0]     o_tile_x,
  output logic [YW-1:0]     o_tile_y
`ifdef EDGE_MCU_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);
  localparam int WIN = OUT_W + 2;
  localparam int CW = $clog2(WIN);
  localparam int OCW = $clog2(OUT_W + 1);
  localparam int OROW = IMG_W - 2;
  // Pointer steps: end-of-row jumps and tile-to-tile moves (next tile row rewinds tx back to 0)
  localparam logic [ADDR_W-1:0] R_NL = ADDR_W'(IMG_W - WIN + 1);
  localparam logic [ADDR_W-1:0] R_TX = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] R_TY = ADDR_W'(OUT_W * IMG_W - (TX - 1) * OUT_W);
  localparam logic [ADDR_W-1:0] W_NL = ADDR_W'(OROW - OUT_W + 1);
  localparam logic [ADDR_W-1:0] W_TX = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] W_TY = ADDR_W'(OUT_W * OROW - (TX - 1) * OUT_W);

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_WAIT, GRAY_START, GRAY_WAIT, B1_SAVE, EDGE_START,
    EDGE_WAIT, B2_SAVE, WR_SLOT, WR_ISSUE, WR_WAIT, TILE_NEXT, DONE
  } state_t;

  state_t r_state, w_nxt;
  logic [CW-1:0] r_r, r_c;
  logic [OCW-1:0] r_or, r_oc;
  logic [ADDR_W-1:0] r_rtile, r_wtile, r_rptr, r_wptr, w_rtile_nxt, w_wtile_nxt;
  logic w_win_done, w_out_done, w_tx_wrap, w_last, w_abort;

  assign w_win_done = (r_r == CW'(WIN - 1)) && (r_c == CW'(WIN - 1));
  assign w_out_done = (r_or == OCW'(OUT_W - 1)) && (r_oc == OCW'(OUT_W - 1));
  assign w_tx_wrap = o_tile_x == XW'(TX - 1);
  assign w_last = w_tx_wrap && (o_tile_y == YW'(TY - 1));
  assign w_abort = i_abort && (r_state != IDLE);
  assign w_rtile_nxt = r_rtile + (w_tx_wrap ? R_TY : R_TX);
  assign w_wtile_nxt = r_wtile + (w_tx_wrap ? W_TY : W_TX);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:       w_nxt = i_start ? RD_ISSUE : IDLE;
      RD_ISSUE:   w_nxt = RD_WAIT;
      RD_WAIT:    w_nxt = i_read_complete ? GRAY_START : RD_WAIT;
      GRAY_START: w_nxt = GRAY_WAIT;
      GRAY_WAIT:  w_nxt = i_grayscale_data_ready ? B1_SAVE : GRAY_WAIT;
      B1_SAVE:    w_nxt = w_win_done ? EDGE_START : RD_ISSUE;
      EDGE_START: w_nxt = EDGE_WAIT;
      EDGE_WAIT:  w_nxt = i_gradient_data_ready ? B2_SAVE : EDGE_WAIT;
      B2_SAVE:    w_nxt = WR_SLOT;
      WR_SLOT:    w_nxt = i_start_next_write ? WR_ISSUE : WR_SLOT;
      WR_ISSUE:   w_nxt = WR_WAIT;
      WR_WAIT:    w_nxt = !i_write_complete ? WR_WAIT : (w_out_done ? TILE_NEXT : WR_SLOT);
      TILE_NEXT:  w_nxt = w_last ? DONE : RD_ISSUE;
      DONE:       w_nxt = IDLE;
      default:    w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      {r_r, r_c, r_or, r_oc, o_tile_x, o_tile_y} <= '0;
      {r_rtile, r_rptr, o_raddr} <= {3{RBASE}};
      {r_wtile, r_wptr, o_waddr} <= {3{WBASE}};
      {o_re, o_grayscale_start, o_b1_save, o_b1_clear, o_gradient_start} <= '0;
      {o_b2_save, o_we, o_busy, o_complete, o_aborted} <= '0;
    end else begin
      r_state <= w_nxt;
      o_busy <= w_nxt != IDLE;
      {o_re, o_grayscale_start, o_b1_save, o_b1_clear, o_gradient_start} <= '0;
      {o_b2_save, o_we, o_complete, o_aborted} <= '0;
      if (w_abort) begin
        o_aborted <= 1'b1;
        {r_r, r_c, r_or, r_oc, o_tile_x, o_tile_y} <= '0;
      end else begin
        case (r_state)
          IDLE: if (i_start) begin
            {r_r, r_c, r_or, r_oc, o_tile_x, o_tile_y} <= '0;
            {r_rtile, r_rptr} <= {2{RBASE}};
            {r_wtile, r_wptr} <= {2{WBASE}};
          end
          RD_ISSUE: begin
            o_raddr <= r_rptr;
            o_re <= 1'b1;
          end
          GRAY_START: o_grayscale_start <= 1'b1;
          B1_SAVE: begin
            o_b1_save <= 1'b1;
            r_c <= (r_c == CW'(WIN - 1)) ? '0 : r_c + 1'b1;
            r_r <= w_win_done ? '0 : (r_c == CW'(WIN - 1)) ? r_r + 1'b1 : r_r;
            r_rptr <= r_rptr + ((r_c == CW'(WIN - 1)) ? R_NL : ADDR_W'(1));
          end
          EDGE_START: o_gradient_start <= 1'b1;
          B2_SAVE: {o_b2_save, o_b1_clear} <= 2'b11;
          WR_ISSUE: begin
            o_waddr <= r_wptr;
            o_we <= 1'b1;
          end
          WR_WAIT: if (i_write_complete) begin
            r_oc <= (r_oc == OCW'(OUT_W - 1)) ? '0 : r_oc + 1'b1;
            r_or <= w_out_done ? '0 : (r_oc == OCW'(OUT_W - 1)) ? r_or + 1'b1 : r_or;
            r_wptr <= r_wptr + ((r_oc == OCW'(OUT_W - 1)) ? W_NL : ADDR_W'(1));
          end
          TILE_NEXT: if (!w_last) begin
            o_tile_x <= w_tx_wrap ? '0 : o_tile_x + 1'b1;
            o_tile_y <= w_tx_wrap ? o_tile_y + 1'b1 : o_tile_y;
            {r_rtile, r_rptr} <= {2{w_rtile_nxt}};
            {r_wtile, r_wptr} <= {2{w_wtile_nxt}};
          end
          DONE: begin
            o_complete <= 1'b1;
            {o_tile_x, o_tile_y} <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef EDGE_MCU_PERF_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) o_stall_cycles <= '0;
    else if (r_state == IDLE && i_start) o_stall_cycles <= '0;
    else if ((r_state inside {RD_WAIT, GRAY_WAIT, EDGE_WAIT, WR_SLOT, WR_WAIT}) && o_stall_cycles != '1)
      o_stall_cycles <= o_stall_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_edge_mcu_tiled.sv
// tb_edge_mcu_tiled: 8x8 image, 3x3 tiles; table of frame runs with random handshake delays plus abort corner cases.
module tb_edge_mcu_tiled;
  localparam int IW = 8, IH = 8, OW = 3, WIN = OW + 2, NTX = 2, NTY = 2, TMO = 20000;
  localparam logic [31:0] RB = 32'h0, WB = 32'h0010_0000;

  logic clk = 1'b0, n_rst = 1'b0;
  logic i_start = 0, i_abort = 0, i_read_complete = 0, i_grayscale_data_ready = 0;
  logic i_gradient_data_ready = 0, i_start_next_write = 0, i_write_complete = 0;
  logic [31:0] o_raddr, o_waddr;
  logic o_re, o_grayscale_start, o_b1_save, o_b1_clear, o_gradient_start, o_b2_save;
  logic o_we, o_busy, o_complete, o_aborted;
  logic [1:0] o_tile_x, o_tile_y;
`ifdef EDGE_MCU_PERF_CNT_EN
  logic [31:0] o_stall_cycles;
`endif

  always #5 clk = ~clk;

  edge_mcu_tiled #(.IMG_W(IW), .IMG_H(IH), .OUT_W(OW), .ADDR_W(32), .RBASE(RB), .WBASE(WB)) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_abort(i_abort),
    .i_read_complete(i_read_complete), .i_grayscale_data_ready(i_grayscale_data_ready),
    .i_gradient_data_ready(i_gradient_data_ready), .i_start_next_write(i_start_next_write),
    .i_write_complete(i_write_complete), .o_raddr(o_raddr), .o_re(o_re),
    .o_grayscale_start(o_grayscale_start), .o_b1_save(o_b1_save), .o_b1_clear(o_b1_clear),
    .o_gradient_start(o_gradient_start), .o_b2_save(o_b2_save), .o_waddr(o_waddr), .o_we(o_we),
    .o_busy(o_busy), .o_complete(o_complete), .o_aborted(o_aborted),
    .o_tile_x(o_tile_x), .o_tile_y(o_tile_y)
`ifdef EDGE_MCU_PERF_CNT_EN
    , .o_stall_cycles(o_stall_cycles)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  int dly = 0;
  bit nw_rand = 0;
  int n_rd, n_wr, n_cpl, n_abt, n_b1, n_b2;

  typedef struct { logic [31:0] a; int x; int y; } ev_t;
  ev_t rq[$], wq[$];

  typedef struct { int d; bit nw; int exp_rd; int exp_wr; int exp_tiles; } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected read/write addresses straight from the tiling rules
  task automatic build_model();
    rq.delete();
    wq.delete();
    for (int ty = 0; ty < NTY; ty++)
      for (int tx = 0; tx < NTX; tx++) begin
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++)
            rq.push_back('{RB + 32'((ty * OW + r) * IW + tx * OW + c), tx, ty});
        for (int orow = 0; orow < OW; orow++)
          for (int ocol = 0; ocol < OW; ocol++)
            wq.push_back('{WB + 32'((ty * OW + orow) * (IW - 2) + tx * OW + ocol), tx, ty});
      end
    {n_rd, n_wr, n_cpl, n_abt, n_b1, n_b2} = '0;
  endtask

  initial forever begin
    @(negedge clk);
    if (o_re) begin
      repeat ($urandom_range(0, dly)) @(negedge clk);
      i_read_complete = 1;
      @(negedge clk);
      i_read_complete = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (o_grayscale_start) begin
      repeat ($urandom_range(0, dly)) @(negedge clk);
      i_grayscale_data_ready = 1;
      @(negedge clk);
      i_grayscale_data_ready = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (o_gradient_start) begin
      repeat ($urandom_range(0, dly)) @(negedge clk);
      i_gradient_data_ready = 1;
      @(negedge clk);
      i_gradient_data_ready = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (o_we) begin
      repeat ($urandom_range(0, dly)) @(negedge clk);
      i_write_complete = 1;
      @(negedge clk);
      i_write_complete = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    i_start_next_write = nw_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  logic [8:0] ps = '0;
  always @(negedge clk) begin
    logic [8:0] s;
    ev_t e;
    s = {o_re, o_grayscale_start, o_b1_save, o_b1_clear, o_gradient_start, o_b2_save, o_we, o_complete, o_aborted};
    if (n_rst) begin
      for (int i = 0; i < 9; i++)
        if (s[i]) chk($sformatf("strobe%0d_width", i), ps[i], 0);
      if (o_re) begin
        n_rd++;
        chk("read_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          e = rq.pop_front();
          chk("raddr", o_raddr, e.a);
          chk("rd_tile_x", o_tile_x, e.x);
          chk("rd_tile_y", o_tile_y, e.y);
        end
      end
      if (o_we) begin
        n_wr++;
        chk("write_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("waddr", o_waddr, e.a);
          chk("wr_tile_x", o_tile_x, e.x);
          chk("wr_tile_y", o_tile_y, e.y);
        end
      end
      if (o_b2_save || o_b1_clear) chk("b2_save_with_b1_clear", o_b2_save, o_b1_clear);
      n_b1 += int'(o_b1_save);
      n_b2 += int'(o_b2_save);
      n_cpl += int'(o_complete);
      n_abt += int'(o_aborted);
    end
    ps = s;
  end

  task automatic run_frame(input int d, input bit nw, input bit with_abort, input int exp_rd, input int exp_wr, input int exp_tiles);
    int t;
    dly = d;
    nw_rand = nw;
    build_model();
    @(negedge clk);
    i_start = 1;
    i_abort = with_abort;
    @(negedge clk);
    i_start = 0;
    i_abort = 0;
    chk("busy_after_start", o_busy, 1);
    chk("re_latency_edge_k", o_re, 0);
    @(negedge clk);
    chk("re_latency_edge_k1", o_re, 1);
    chk("first_raddr", o_raddr, RB);
    t = 0;
    while (!o_complete && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_in_time", t < TMO, 1);
    @(negedge clk);
    chk("complete_pulses", n_cpl, 1);
    chk("aborted_pulses", n_abt, 0);
    chk("busy_after_done", o_busy, 0);
    chk("reads", n_rd, exp_rd);
    chk("writes", n_wr, exp_wr);
    chk("b1_saves", n_b1, exp_rd);
    chk("b2_saves", n_b2, exp_tiles);
    chk("reads_left", rq.size(), 0);
    chk("writes_left", wq.size(), 0);
    chk("raddr_held", o_raddr, RB + 63);
    chk("waddr_held", o_waddr, WB + 35);
    chk("tile_x_idle", o_tile_x, 0);
    chk("tile_y_idle", o_tile_y, 0);
  endtask

  initial begin
    int cnt, t;
    vt[0] = '{0, 0, 100, 36, 4};
    vt[1] = '{5, 1, 100, 36, 4};
    vt[2] = '{2, 0, 100, 36, 4};
    vt[3] = '{1, 1, 100, 36, 4};
    repeat (3) @(negedge clk);
    chk("reset_re", o_re, 0);
    chk("reset_raddr", o_raddr, RB);
    chk("reset_waddr", o_waddr, WB);
    n_rst = 1;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_we", o_we, 0);
    chk("idle_complete", o_complete, 0);
    chk("idle_tile_x", o_tile_x, 0);
    chk("idle_tile_y", o_tile_y, 0);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
    chk("idle_abort_ignored_busy", o_busy, 0);
    chk("idle_abort_ignored_ack", o_aborted, 0);
    @(negedge clk);
    chk("idle_abort_ignored_ack2", o_aborted, 0);

    for (int i = 0; i < 4; i++)
      run_frame(vt[i].d, vt[i].nw, 1'b0, vt[i].exp_rd, vt[i].exp_wr, vt[i].exp_tiles);

    // Abort on the third write of tile (1,0), i.e. the 12th write of the frame
    dly = 0;
    nw_rand = 0;
    build_model();
    @(negedge clk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    cnt = 0;
    t = 0;
    while (t < TMO) begin
      @(negedge clk);
      t++;
      if (o_we) begin
        cnt++;
        if (cnt == 12) break;
      end
    end
    chk("abort_point_reached", cnt, 12);
    chk("abort_point_waddr", o_waddr, WB + 5);
    chk("abort_point_tile_x", o_tile_x, 1);
    chk("abort_point_tile_y", o_tile_y, 0);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
    chk("abort_busy", o_busy, 0);
    chk("abort_ack", o_aborted, 1);
    chk("abort_no_we", o_we, 0);
    chk("abort_no_complete", o_complete, 0);
    chk("abort_tile_x", o_tile_x, 0);
    @(negedge clk);
    chk("abort_ack_one_cycle", o_aborted, 0);
    repeat (5) @(negedge clk);
    chk("abort_total_acks", n_abt, 1);
    chk("abort_total_completes", n_cpl, 0);
    chk("abort_busy_settled", o_busy, 0);

    // Restart with start and abort together: start wins, frame restarts at address 0
    run_frame(0, 1'b0, 1'b1, 100, 36, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
